alu_ctrl_seq: RTL and testbench

//  Multi-cycle ALU control for the multi-cycle datapath; successor to the single-cycle combinational ALU control.

---
 rtl/alu_ctrl_pkg.sv | 41 ++++
 rtl/alu_ctrl_decode.sv | 55 +++++
 rtl/alu_ctrl_seq.sv | 100 ++++++++++
 tb/tb_alu_ctrl_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the multi-cycle ALU control: select codes, alu_op and
// funct encodings, and the sequencer state type.
package alu_ctrl_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] SEL_AND  = 4'b0000;
  localparam logic [CODE_W-1:0] SEL_OR   = 4'b0001;
  localparam logic [CODE_W-1:0] SEL_ADD  = 4'b0010;
  localparam logic [CODE_W-1:0] SEL_SLT  = 4'b0011;
  localparam logic [CODE_W-1:0] SEL_ADDU = 4'b0100;
  localparam logic [CODE_W-1:0] SEL_SLL  = 4'b0101;
  localparam logic [CODE_W-1:0] SEL_SUB  = 4'b0110;
  localparam logic [CODE_W-1:0] SEL_SLTU = 4'b0111;
  localparam logic [CODE_W-1:0] SEL_SRA  = 4'b1001;
  localparam logic [CODE_W-1:0] SEL_SRL  = 4'b1101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/funct into an ALU select code, a shift flag
// and an illegal flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit EN_SRX = 1'b1
) (
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  output logic [CODE_W-1:0] sel_code,
  output logic              is_shift,
  output logic              illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    sel_code = SEL_AND;
    is_shift = 1'b0;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_ADD: sel_code = SEL_ADD;
      ALUOP_SUB: sel_code = SEL_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          F_ADD:  sel_code = SEL_ADD;
          F_ADDU: sel_code = SEL_ADDU;
          F_SUB,
          F_SUBU: sel_code = SEL_SUB;
          F_AND:  sel_code = SEL_AND;
          F_OR:   sel_code = SEL_OR;
          F_SLT:  sel_code = SEL_SLT;
          F_SLTU: sel_code = SEL_SLTU;
          F_SLL: begin
            sel_code = SEL_SLL;
            is_shift = 1'b1;
          end
          // Right shifts exist only in builds with the extended shifter.
          F_SRL: begin
            sel_code = SEL_SRL;
            is_shift = EN_SRX;
            illegal  = !EN_SRX;
          end
          F_SRA: begin
            sel_code = SEL_SRA;
            is_shift = EN_SRX;
            illegal  = !EN_SRX;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Multi-cycle ALU control sequencer: accepts one op per handshake, holds sel,
// steps the 1-bit shifter shamt times, then strobes res_we and done.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int SHAMT_W = 5,
  parameter bit EN_SRX  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [SEL_W-1:0]   sel,
  output logic               shift_en,
  output logic               res_we,
  output logic               done,
  output logic               illegal
);

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [CODE_W-1:0]  dec_sel;
  logic               dec_shift;
  logic               dec_illegal;
  logic               accept;

  alu_ctrl_decode #(.EN_SRX(EN_SRX)) u_decode (
    .alu_op   (alu_op),
    .funct    (funct),
    .sel_code (dec_sel),
    .is_shift (dec_shift),
    .illegal  (dec_illegal)
  );

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign op_ready = rst_n & (state == ST_IDLE || state == ST_DONE);
  assign accept   = op_valid & op_ready;

  always_ff @(posedge clk) begin
    // NOTE: the reset branch covers every register; there is no storage array to leave unreset.
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= '0;
      cnt      <= '0;
      shift_en <= 1'b0;
      res_we   <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      shift_en <= 1'b0;
      res_we   <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            cnt <= shamt;
            if (dec_illegal) begin
              // sel keeps the previous op's code so the ALU sees no glitch.
              state   <= ST_DONE;
              done    <= 1'b1;
              illegal <= 1'b1;
            end else begin
              sel <= SEL_W'(dec_sel);
              if (dec_shift && shamt != '0) begin
                state    <= ST_SHIFT;
                shift_en <= 1'b1;
              end else begin
                state  <= ST_EXEC;
                res_we <= 1'b1;
              end
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state  <= ST_EXEC;
            res_we <= 1'b1;
          end else begin
            shift_en <= 1'b1;
          end
        end
        ST_EXEC: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: two instances (right shifts enabled and
// disabled) driven by directed ops; a negedge monitor pops expectations on done.
module tb_alu_ctrl_seq;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v0 = 1'b0, r0, se0, we0, dn0, il0;
  logic [1:0] op0 = '0;
  logic [5:0] f0 = '0;
  logic [4:0] sh0 = '0;
  logic [3:0] sel0;

  logic       v1 = 1'b0, r1, se1, we1, dn1, il1;
  logic [1:0] op1 = '0;
  logic [5:0] f1 = '0;
  logic [4:0] sh1 = '0;
  logic [3:0] sel1;

  alu_ctrl_seq #(.SEL_W(4), .SHAMT_W(5), .EN_SRX(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(v0), .op_ready(r0), .alu_op(op0),
    .funct(f0), .shamt(sh0), .sel(sel0), .shift_en(se0), .res_we(we0),
    .done(dn0), .illegal(il0)
  );

  alu_ctrl_seq #(.SEL_W(4), .SHAMT_W(5), .EN_SRX(1'b0)) dut_nosrx (
    .clk(clk), .rst_n(rst_n), .op_valid(v1), .op_ready(r1), .alu_op(op1),
    .funct(f1), .shamt(sh1), .sel(sel1), .shift_en(se1), .res_we(we1),
    .done(dn1), .illegal(il1)
  );

  typedef struct {
    int         acc;
    logic [3:0] sel;
    logic       ill;
    int         shifts;
    int         done_off;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   shifts_seen[2];
  int   we_seen[2];
  int   we_cyc[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic se, input logic we, input logic dn,
                     input logic il, input logic [3:0] sel);
    exp_t e;
    bit   have;
    if (!rst_n) begin
      shifts_seen[d] = 0;
      we_seen[d] = 0;
      return;
    end
    if (se || we || dn || il) begin
      check($sformatf("strobe_exclusive_%0d", d), int'(se) + int'(we) + int'(dn), 1);
      check($sformatf("illegal_only_with_done_%0d", d), int'(il & !dn), 0);
    end
    if (se) shifts_seen[d]++;
    if (we) begin
      we_seen[d]++;
      we_cyc[d] = cyc;
    end
    if (dn) begin
      have = 1'b0;
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        check($sformatf("unexpected_done_%0d", d), 1, 0);
      end else begin
        check($sformatf("done_latency_%0d", d), cyc - e.acc, e.done_off);
        check($sformatf("illegal_%0d", d), int'(il), int'(e.ill));
        check($sformatf("sel_%0d", d), int'(sel), int'(e.sel));
        check($sformatf("shift_cycles_%0d", d), shifts_seen[d], e.shifts);
        check($sformatf("res_we_count_%0d", d), we_seen[d], e.ill ? 0 : 1);
        if (!e.ill) check($sformatf("res_we_latency_%0d", d), we_cyc[d] - e.acc, e.done_off - 1);
      end
      shifts_seen[d] = 0;
      we_seen[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, se0, we0, dn0, il0, sel0);
    mon(1, se1, we1, dn1, il1, sel1);
  end

  // Drive one op, wait for acceptance, push the expectation; returns in the cycle after accept.
  task automatic issue(input int d, input logic [1:0] op, input logic [5:0] fn,
                       input logic [4:0] sa, input logic [3:0] es, input logic ei,
                       input int esh, input int eoff, input bit hold, input bit push,
                       output int acc);
    exp_t e;
    int   n = 0;
    logic rdy;
    if (d == 0) begin v0 = 1'b1; op0 = op; f0 = fn; sh0 = sa; end
    else        begin v1 = 1'b1; op1 = op; f1 = fn; sh1 = sa; end
    do begin
      @(negedge clk);
      n++;
      rdy = (d == 0) ? r0 : r1;
    end while (!rdy && n < 100);
    acc = cyc;
    if (!rdy) begin
      check("accept_timeout", 0, 1);
    end else if (push) begin
      e.acc = cyc; e.sel = es; e.ill = ei; e.shifts = esh; e.done_off = eoff;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      // Scramble the held fields: the op in flight must not notice.
      if (d == 0) begin v0 = 1'b0; op0 = 2'($urandom); f0 = 6'($urandom); sh0 = 5'($urandom); end
      else        begin v1 = 1'b0; op1 = 2'($urandom); f1 = 6'($urandom); sh1 = 5'($urandom); end
    end
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int d, input logic [1:0] op, input logic [5:0] fn,
                     input logic [4:0] sa, input logic [3:0] es, input logic ei,
                     input int esh, input int eoff);
    int acc;
    issue(d, op, fn, sa, es, ei, esh, eoff, 1'b0, 1'b1, acc);
    wait_done(d);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int a1, a2, ax;

    repeat (3) @(negedge clk);
    check("rst_sel0", sel0, 0);
    check("rst_ready0", r0, 0);
    check("rst_strobes0", {se0, we0, dn0, il0}, 0);
    check("rst_sel1", sel1, 0);
    check("rst_ready1", r1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release0", r0, 1);
    check("ready_after_release1", r1, 1);
    @(posedge clk); #1;

    //     d op     funct      sa  sel      ill  sh  off
    run(0, 2'b10, 6'b100010, 0,  4'b0110, 0,   0,  2);
    run(0, 2'b10, 6'b000000, 5,  4'b0101, 0,   5,  7);
    run(0, 2'b10, 6'b000000, 0,  4'b0101, 0,   0,  2);
    run(0, 2'b10, 6'b000000, 31, 4'b0101, 0,  31, 33);
    run(0, 2'b10, 6'b100000, 9,  4'b0010, 0,   0,  2);
    run(0, 2'b10, 6'b100001, 0,  4'b0100, 0,   0,  2);
    run(0, 2'b10, 6'b100011, 0,  4'b0110, 0,   0,  2);
    run(0, 2'b10, 6'b100100, 0,  4'b0000, 0,   0,  2);
    run(0, 2'b10, 6'b100101, 0,  4'b0001, 0,   0,  2);
    run(0, 2'b10, 6'b101010, 0,  4'b0011, 0,   0,  2);
    run(0, 2'b10, 6'b101011, 0,  4'b0111, 0,   0,  2);
    run(0, 2'b10, 6'b000010, 3,  4'b1101, 0,   3,  5);
    run(0, 2'b10, 6'b000011, 2,  4'b1001, 0,   2,  4);
    run(0, 2'b10, 6'b111111, 4,  4'b1001, 1,   0,  1);
    run(0, 2'b11, 6'b100000, 0,  4'b1001, 1,   0,  1);
    run(0, 2'b00, 6'b000000, 6,  4'b0010, 0,   0,  2);

    // Back-to-back with op_valid held: second op taken in the DONE cycle.
    issue(0, 2'b00, 6'b000000, 0, 4'b0010, 0, 0, 2, 1'b1, 1'b1, a1);
    issue(0, 2'b01, 6'b000000, 0, 4'b0110, 0, 0, 2, 1'b0, 1'b1, a2);
    check("back_to_back_gap", a2 - a1, 2);
    wait_done(0);

    // Instance without right shifts.
    run(1, 2'b00, 6'b000000, 0, 4'b0010, 0, 0, 2);
    run(1, 2'b10, 6'b000010, 1, 4'b0010, 1, 0, 1);
    run(1, 2'b11, 6'b000000, 0, 4'b0010, 1, 0, 1);
    run(1, 2'b10, 6'b000011, 4, 4'b0010, 1, 0, 1);
    run(1, 2'b10, 6'b000000, 2, 4'b0101, 0, 2, 4);

    // SRA shamt=7 aborted by reset at T+3: no done may follow.
    issue(0, 2'b10, 6'b000011, 7, 4'b1001, 0, 7, 9, 1'b0, 1'b0, ax);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("ready_low_in_reset", r0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_sel", sel0, 0);
    check("abort_strobes", {se0, we0, dn0, il0}, 0);
    check("abort_ready", r0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", r0, 1);
    @(posedge clk); #1;
    run(0, 2'b00, 6'b000000, 0, 4'b0010, 0, 0, 2);

    repeat (12) @(negedge clk);
    check("queue0_empty", q0.size(), 0);
    check("queue1_empty", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
